// File: rtl/fifo_ram_param_pkg.sv
// Shared constants, types and helpers for the parametrised RAM FIFO.
package fifo_ram_param_pkg;

  // Ceiling log2, usable in constant expressions (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Occupancy counter width: one extra bit so DEPTH itself is representable.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Bit positions used when the upstream controller packs flags into a status register.
  localparam int FLAG_EMPTY        = 0;
  localparam int FLAG_FULL         = 1;
  localparam int FLAG_ALMOST_EMPTY = 2;
  localparam int FLAG_ALMOST_FULL  = 3;
  localparam int FLAG_OVERFLOW     = 4;
  localparam int FLAG_UNDERFLOW    = 5;
  localparam int FLAG_BITS         = 6;

  // Packed status word; member order matches the FLAG_* positions (empty is bit 0).
  typedef struct packed {
    logic underflow;
    logic overflow;
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } status_t;

  // Accepted operation this cycle, encoded as {write_ok, read_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ram_array.sv
// WIDTH x DEPTH register-file store: one synchronous write port and one
// registered read port. The read register is the FIFO's Data_Out.
module fifo_ram_array
  import fifo_ram_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset so it maps onto plain register/RAM cells.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store on accepted writes only.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: old contents are returned when read and write hit the same
  // entry (full + simultaneous access), so there is no write-to-read bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_ram_param.sv
// Parametrised synchronous FIFO: pointer, occupancy, flag and sticky error
// logic around a fifo_ram_array store.
module fifo_ram_param
  import fifo_ram_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Write_Enable,
  input  logic [WIDTH-1:0]              Data_In,
  input  logic                          Read_Enable,
  input  logic                          Clear_Errors,
  output logic [WIDTH-1:0]              Data_Out,
  output logic                          Full,
  output logic                          Empty,
  output logic                          Almost_Full,
  output logic                          Almost_Empty,
  output logic [count_width(DEPTH)-1:0] Count,
  output logic                          Overflow,
  output logic                          Underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok, wr_rej, rd_rej;
  op_e           op;
  status_t       st;

  // Flags decode the registered Count directly, so they never lag it.
  always_comb begin
    st              = '0;
    st.empty        = (Count == '0);
    st.full         = (Count == DEPTH_C);
    st.almost_empty = (Count <= AE_C);
    st.almost_full  = (Count >= AF_C);
    st.overflow     = Overflow;
    st.underflow    = Underflow;
  end

  assign Empty        = st.empty;
  assign Full         = st.full;
  assign Almost_Empty = st.almost_empty;
  assign Almost_Full  = st.almost_full;

  // A read frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when paired with a read.
  assign rd_ok  = Read_Enable && !st.empty;
  assign wr_ok  = Write_Enable && (!st.full || rd_ok);
  assign rd_rej = Read_Enable && st.empty;
  assign wr_rej = Write_Enable && !wr_ok;
  assign op     = op_e'({wr_ok, rd_ok});

  // Pointers advance on accepted accesses and wrap naturally at DEPTH (power of two).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 on write only, -1 on read only; acceptance rules keep it in 0..DEPTH.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
    end else begin
      case (op)
        OP_WR:   Count <= Count + 1'b1;
        OP_RD:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (wr_rej)            Overflow  <= 1'b1;
      else if (Clear_Errors) Overflow  <= 1'b0;
      if (rd_rej)            Underflow <= 1'b1;
      else if (Clear_Errors) Underflow <= 1'b0;
    end
  end

  fifo_ram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (Data_In),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (Data_Out)
  );

endmodule

// File: tb/tb_fifo_ram_param.sv
// Self-checking bench for fifo_ram_param (WIDTH=8, DEPTH=32): a queue model
// predicts each word, errors and occupancy as stimulus is applied.
module tb_fifo_ram_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             Write_Enable = 1'b0;
  logic [WIDTH-1:0] Data_In = '0;
  logic             Read_Enable = 1'b0;
  logic             Clear_Errors = 1'b0;
  logic [WIDTH-1:0] Data_Out;
  logic             Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow;
  logic [5:0]       Count;

  int total = 0;
  int bad   = 0;

  // Scoreboard model
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf  = 1'b0;
  logic             m_unf  = 1'b0;

  fifo_ram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .Clock(Clock), .Reset(Reset), .Write_Enable(Write_Enable), .Data_In(Data_In),
    .Read_Enable(Read_Enable), .Clear_Errors(Clear_Errors), .Data_Out(Data_Out),
    .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  // Apply one cycle of stimulus, update the model, return 1 time unit after the edge.
  task automatic drive(input logic we, input logic [WIDTH-1:0] din, input logic re, input logic clr);
    bit rd_ok, wr_ok;
    Write_Enable = we; Data_In = din; Read_Enable = re; Clear_Errors = clr;
    rd_ok = re && (q.size() != 0);
    wr_ok = we && ((q.size() < DEPTH) || rd_ok);
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    if (we && !wr_ok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (re && !rd_ok) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    @(posedge Clock); #1;
    Write_Enable = 1'b0; Read_Enable = 1'b0; Clear_Errors = 1'b0;
  endtask

  task automatic model_reset();
    q.delete(); m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    model_reset();
    #1;
    total++; if (Count !== 6'd0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
    total++; if (Empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", Empty); end
    total++; if (Full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", Full); end
    total++; if (Almost_Empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", Almost_Empty); end
    total++; if (Almost_Full !== 1'b0)  begin bad++; $display("FAIL reset_af got=%b exp=0", Almost_Full); end
    total++; if (Data_Out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", Data_Out); end
    total++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", Overflow, Underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      total++; if (Count !== 6'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, Count, i); end
      total++; if (Almost_Full !== (i >= 28)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, Almost_Full, i >= 28); end
      total++; if (Almost_Empty !== (i <= 4)) begin bad++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, Almost_Empty, i <= 4); end
      total++; if (Full !== (i == DEPTH)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, Full, i == DEPTH); end
      total++; if (Empty !== 1'b0) begin bad++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, Empty); end
    end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", Overflow); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
    total++; if (Count !== 6'd32)   begin bad++; $display("FAIL ovf_count got=%0d exp=32", Count); end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (Data_Out !== 8'(i)) begin bad++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, Data_Out, 8'(i)); end
      total++; if (Data_Out !== m_dout) begin bad++; $display("FAIL ovf_drain_sb i=%0d got=%h exp=%h", i, Data_Out, m_dout); end
    end
    total++; if (Empty !== 1'b1 || Count !== 6'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d exp=1/0", Empty, Count); end
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (Overflow !== m_ovf) begin bad++; $display("FAIL ovf_clear got=%b exp=%b", Overflow, m_ovf); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (Underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", Underflow); end
    total++; if (Data_Out !== 8'h20) begin bad++; $display("FAIL unf_dout got=%h exp=20", Data_Out); end
    total++; if (Count !== 6'd0)     begin bad++; $display("FAIL unf_count got=%0d exp=0", Count); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (Underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", Underflow); end
  endtask

  task automatic test_rw_empty();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    total++; if (Count !== 6'd1)     begin bad++; $display("FAIL rwe_count got=%0d exp=1", Count); end
    total++; if (Underflow !== 1'b1) begin bad++; $display("FAIL rwe_unf got=%b exp=1", Underflow); end
    total++; if (Data_Out !== 8'h20) begin bad++; $display("FAIL rwe_nobypass got=%h exp=20", Data_Out); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (Data_Out !== 8'h55) begin bad++; $display("FAIL rwe_read got=%h exp=55", Data_Out); end
    total++; if (Empty !== 1'b1)     begin bad++; $display("FAIL rwe_empty got=%b exp=1", Empty); end
    // error raised in the same cycle as a clear must stay set
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (Underflow !== 1'b1) begin bad++; $display("FAIL clr_priority got=%b exp=1", Underflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (Underflow !== m_unf) begin bad++; $display("FAIL clr_after got=%b exp=%b", Underflow, m_unf); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 200)), 1'b0, 1'b0);
    total++; if (Full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", Full); end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'hCC, 1'b1, 1'b0);
      total++; if (Count !== 6'd32)   begin bad++; $display("FAIL b2b_count i=%0d got=%0d exp=32", i, Count); end
      total++; if (Data_Out !== m_dout) begin bad++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, Data_Out, m_dout); end
      if (i >= DEPTH) begin
        total++; if (Data_Out !== 8'hCC) begin bad++; $display("FAIL b2b_cc i=%0d got=%h exp=cc", i, Data_Out); end
      end
    end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", Overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (Data_Out !== m_dout) begin bad++; $display("FAIL b2b_drain i=%0d got=%h exp=%h", i, Data_Out, m_dout); end
    end
    total++; if (Empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", Empty); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 8'h00, 1'b1, 1'b0);  // leave Underflow set before the reset
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);  // Data_Out becomes 0x80, Count 16
    drive(1'b1, 8'h91, 1'b0, 1'b0);  // Count back to 17
    total++; if (Count !== 6'd17) begin bad++; $display("FAIL mid_count got=%0d exp=17", Count); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);  // Data_Out 0x81, Count 16
    drive(1'b1, 8'h92, 1'b0, 1'b0);  // Count 17
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h93, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 Reset = 1'b1;
    #1;
    total++; if (Count !== 6'd0 || Empty !== 1'b1 || Full !== 1'b0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%b/%b exp=0/1/0", Count, Empty, Full); end
    total++; if (Almost_Empty !== 1'b1 || Almost_Full !== 1'b0) begin bad++; $display("FAIL mid_rst_almost got=%b/%b exp=1/0", Almost_Empty, Almost_Full); end
    total++; if (Data_Out !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%h exp=00", Data_Out); end
    total++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b%b exp=00", Overflow, Underflow); end
    @(posedge Clock); #1 Reset = 1'b0;
    model_reset();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (Data_Out !== 8'h3C) begin bad++; $display("FAIL mid_after got=%h exp=3c", Data_Out); end
    total++; if (Data_Out !== m_dout || Empty !== 1'b1) begin bad++; $display("FAIL mid_after_sb got=%h/%b exp=%h/1", Data_Out, Empty, m_dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_rw_empty();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
